// File: rtl/i2s_serializer.sv
// Philips I2S transmitter: mono PCM word duplicated to left/right, MSB first, lrclk leads MSB by one bclk.
// Latency: a word latched on frame start reaches sdata in the same tick; first ack 2*BCLK_DIV clocks after reset.
// Backpressure: none; upstream holds sample across the ack cycle, a missed update repeats the previous word.
module i2s_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    sample_ack,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata
);

  localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SAMPLE_WIDTH - 1);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    ack_q, ack_d;

  logic                    div_wrap;
  logic                    fall_tick;
  logic                    frame_start;
  logic [BIT_W-1:0]        bit_next;
  logic [SAMPLE_WIDTH-1:0] load_word;

  // Divider, bit counter and serializer next-state; lrclk/sdata only move on bclk falling ticks.
  always_comb begin
    div_wrap    = (div_cnt_q == DIV_LAST);
    fall_tick   = div_wrap && bclk_q;
    frame_start = fall_tick && (bit_cnt_q == BIT_LAST);
    bit_next    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    load_word   = enable ? sample : '0;

    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    ack_d     = 1'b0;

    if (fall_tick) begin
      bit_cnt_d = bit_next;
      // Right channel select spans the left LSB through the bit before the right LSB.
      lrclk_d   = (bit_next >= LR_FIRST) && (bit_next != BIT_LAST);
      if (frame_start) begin
        // Both channel copies are loaded at once; the MSB goes straight to sdata.
        sdata_d = load_word[SAMPLE_WIDTH-1];
        shift_d = {load_word[SAMPLE_WIDTH-2:0], load_word, 1'b0};
        ack_d   = 1'b1;
      end else begin
        sdata_d = shift_q[FRAME_BITS-1];
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // State registers; reset parks the counter at the last bit so the first tick starts a frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      shift_q   <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      ack_q     <= ack_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign sample_ack = ack_q;

endmodule

// File: tb/tb_i2s_serializer.sv
module tb_i2s_serializer;

  localparam int W  = 16;
  localparam int D0 = 2;
  localparam int D1 = 1;

  logic          clock  = 1'b0;
  logic          reset  = 1'b0;
  logic          enable = 1'b0;
  logic [W-1:0]  sample = '0;

  logic ack0, bclk0, lr0, sd0;
  logic ack1, bclk1, lr1, sd1;

  always #5 clock = ~clock;

  i2s_serializer #(.SAMPLE_WIDTH(W), .BCLK_DIV(D0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .sample(sample),
    .sample_ack(ack0), .bclk(bclk0), .lrclk(lr0), .sdata(sd0)
  );

  i2s_serializer #(.SAMPLE_WIDTH(W), .BCLK_DIV(D1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .sample(sample),
    .sample_ack(ack1), .bclk(bclk1), .lrclk(lr1), .sdata(sd1)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int last_ack0 = -1;
  int last_ack1 = -1;
  int first_ack1 = -1;

  // Reference model: clocks since reset release plus the word latched for the current frame.
  int           t0 = 0;
  int           t1 = 0;
  logic [W-1:0] w0 = '0;
  logic [W-1:0] w1 = '0;

  // Frame k (k>=1) begins at clock 2*D*k; a new word is taken when the bit index of that tick is 0.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      t0 = 0;
      t1 = 0;
    end else begin
      t0 = t0 + 1;
      t1 = t1 + 1;
      if ((t0 % (2*D0)) == 0 && (((t0 / (2*D0)) - 1) % (2*W)) == 0) w0 = enable ? sample : '0;
      if ((t1 % (2*D1)) == 0 && (((t1 / (2*D1)) - 1) % (2*W)) == 0) w1 = enable ? sample : '0;
    end
  end

  // Expected {bclk, lrclk, sdata, sample_ack} after t clocks, from the I2S framing rules.
  function automatic logic [3:0] model_out(input int t, input int d, input logic [W-1:0] w);
    int   k;
    int   b;
    logic bc, lr, sd, ak;
    bc = ((t / d) % 2) == 1;
    k  = t / (2*d);
    if (k == 0) return {bc, 3'b000};
    b  = (k - 1) % (2*W);
    sd = (b < W) ? w[W-1-b] : w[2*W-1-b];
    lr = (b >= W-1) && (b <= 2*W-2);
    ak = ((t % (2*d)) == 0) && (b == 0);
    return {bc, lr, sd, ak};
  endfunction

  task automatic check_outputs();
    logic [3:0] e0, e1;
    e0 = model_out(t0, D0, w0);
    e1 = model_out(t1, D1, w1);
    n_checks++;
    assert ({bclk0, lr0, sd0, ack0} === e0)
      else begin n_errors++; $error("FAIL div2_outputs cyc=%0d got %b expected %b", cyc, {bclk0, lr0, sd0, ack0}, e0); end
    n_checks++;
    assert ({bclk1, lr1, sd1, ack1} === e1)
      else begin n_errors++; $error("FAIL div1_outputs cyc=%0d got %b expected %b", cyc, {bclk1, lr1, sd1, ack1}, e1); end
  endtask

  // One clock: sample outputs on the falling edge, then check data and ack spacing.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check_outputs();
    if (ack0 === 1'b1) begin
      if (last_ack0 >= 0) begin
        n_checks++;
        assert ((cyc - last_ack0) === 128)
          else begin n_errors++; $error("FAIL div2_ack_spacing got %0d expected 128", cyc - last_ack0); end
      end
      last_ack0 = cyc;
    end
    if (ack1 === 1'b1) begin
      if (first_ack1 < 0) first_ack1 = cyc;
      if (last_ack1 >= 0) begin
        n_checks++;
        assert ((cyc - last_ack1) === 64)
          else begin n_errors++; $error("FAIL div1_ack_spacing got %0d expected 64", cyc - last_ack1); end
      end
      last_ack1 = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ack0(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ack0 !== 1'b1 && n < 400);
    n_checks++;
    assert (ack0 === 1'b1)
      else begin n_errors++; $error("FAIL ack0_timeout got %b expected 1 within 400 clocks", ack0); end
  endtask

  int n;

  initial begin
    // Scenario 1: reset held for 3 clocks, then release timing.
    enable = 1'b1;
    sample = 16'h00ff;
    reset  = 1'b0;
    run(3);
    n_checks++;
    assert ({bclk0, lr0, sd0, ack0, bclk1, lr1, sd1, ack1} === 8'h00)
      else begin n_errors++; $error("FAIL reset_state got %b expected 00000000", {bclk0, lr0, sd0, ack0, bclk1, lr1, sd1, ack1}); end
    reset = 1'b1;
    cyc = 0;
    first_ack1 = -1;
    wait_ack0(n);
    n_checks++;
    assert (n === 4) else begin n_errors++; $error("FAIL first_ack_div2 got %0d expected 4", n); end
    n_checks++;
    assert (first_ack1 === 2) else begin n_errors++; $error("FAIL first_ack_div1 got %0d expected 2", first_ack1); end

    // Scenario 2/3: 00ff frame in flight, sample changes mid-frame to 8001.
    run(60);
    sample = 16'h8001;
    wait_ack0(n);
    n_checks++;
    assert (n === 68) else begin n_errors++; $error("FAIL ack_after_update got %0d expected 68", n); end

    // Scenario 4: drop enable at left bit 5; this frame keeps 8001, the next is zeros.
    run(20);
    enable = 1'b0;
    wait_ack0(n);
    run(127);

    // Most negative word, then reset asserted at bit 20 of the frame.
    enable = 1'b1;
    sample = 16'h8000;
    wait_ack0(n);
    run(80);
    reset = 1'b0;
    last_ack0 = -1;
    last_ack1 = -1;
    #1;
    n_checks++;
    assert ({bclk0, lr0, sd0, ack0, bclk1, lr1, sd1, ack1} === 8'h00)
      else begin n_errors++; $error("FAIL async_reset got %b expected 00000000", {bclk0, lr0, sd0, ack0, bclk1, lr1, sd1, ack1}); end
    run(3);
    sample = 16'h5a3c;
    reset = 1'b1;
    cyc = 0;
    first_ack1 = -1;
    wait_ack0(n);
    n_checks++;
    assert (n === 4) else begin n_errors++; $error("FAIL ack_after_rerelease got %0d expected 4", n); end
    n_checks++;
    assert (first_ack1 === 2) else begin n_errors++; $error("FAIL div1_ack_after_rerelease got %0d expected 2", first_ack1); end
    run(130);

    // Randomized words, enable and update timing against the model.
    for (int i = 0; i < 16; i++) begin
      sample = W'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      run($urandom_range(1, 200));
    end
    run(140);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
